// File: rtl/asteroids_pkg.sv
// Shared constants and encodings for the DE2 asteroids datapath blocks.
// Screen geometry, facing directions, colours and the bullet FSM encoding.
package asteroids_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SHIP_X   = 80;
  localparam int SHIP_Y   = 60;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;

  typedef enum logic [2:0] {
    B_IDLE  = 3'd0,
    B_DRAW  = 3'd1,
    B_WAIT  = 3'd2,
    B_ERASE = 3'd3,
    B_MOVE  = 3'd4
  } bullet_state_e;

  // True when one more step along dir would leave the screen.
  function automatic logic at_edge(input logic [1:0] dir,
                                   input logic [7:0] px,
                                   input logic [6:0] py,
                                   input logic [7:0] x_max,
                                   input logic [6:0] y_max);
    logic hit;
    hit = 1'b0;
    case (dir)
      DIR_UP:    hit = (py == 7'd0);
      DIR_DOWN:  hit = (py == y_max);
      DIR_RIGHT: hit = (px == x_max);
      DIR_LEFT:  hit = (px == 8'd0);
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/bullet_engine.sv
// Single-bullet motion and pixel plotter: draws, waits for a tick, erases,
// steps one pixel, and retires the bullet at the screen edge.
module bullet_engine
  import asteroids_pkg::*;
#(
  parameter logic [7:0] X_START       = 8'(SHIP_X),
  parameter logic [6:0] Y_START       = 7'(SHIP_Y),
  parameter logic [7:0] X_MAX         = 8'(SCREEN_W - 1),
  parameter logic [6:0] Y_MAX         = 7'(SCREEN_H - 1),
  parameter logic [2:0] BULLET_COLOUR = COL_WHITE
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       fire,
  input  logic [1:0] direction,
  input  logic       tick,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  bullet_state_e state, state_nx;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic [1:0] dir_q;
  logic       launch, step, edge_hit;

  assign edge_hit = at_edge(dir_q, pos_x, pos_y, X_MAX, Y_MAX);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= B_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    step     = 1'b0;
    case (state)
      B_IDLE: if (fire) begin
        launch   = 1'b1;
        state_nx = B_DRAW;
      end
      B_DRAW:  state_nx = B_WAIT;
      B_WAIT:  if (tick) state_nx = B_ERASE;
      B_ERASE: state_nx = B_MOVE;
      B_MOVE: begin
        // Boundary is checked before stepping so the position never wraps.
        if (edge_hit) state_nx = B_IDLE;
        else begin
          step     = 1'b1;
          state_nx = B_DRAW;
        end
      end
      default: state_nx = B_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pos_x <= X_START;
      pos_y <= Y_START;
      dir_q <= DIR_UP;
    end else if (launch) begin
      pos_x <= X_START;
      pos_y <= Y_START;
      dir_q <= direction;
    end else if (step) begin
      case (dir_q)
        DIR_UP:    pos_y <= pos_y - 7'd1;
        DIR_DOWN:  pos_y <= pos_y + 7'd1;
        DIR_RIGHT: pos_x <= pos_x + 8'd1;
        default:   pos_x <= pos_x - 8'd1;
      endcase
    end
  end

  assign x      = pos_x;
  assign y      = pos_y;
  assign plot   = (state == B_DRAW) || (state == B_ERASE);
  assign colour = (state == B_DRAW) ? BULLET_COLOUR : COL_BLACK;
  assign busy   = (state != B_IDLE);
  assign done   = (state == B_MOVE) && edge_hit;

endmodule

// File: doc/bullet_engine.md
# bullet_engine

Bullet motion and pixel-plotting stage for the DE2 asteroids game. It sits downstream of the ship-drawing blocks, which supply a 2-bit facing `direction`. It sits upstream of the VGA adapter, to which it emits one-pixel `x`/`y`/`colour`/`plot` writes. On a `fire` request it launches one bullet from the ship centre and steps it one pixel per `tick`, erasing the old pixel before drawing the new one. It retires the bullet when it reaches the screen edge.

## Interface
Parameters:
- `X_START`, 80: launch x (ship centre).
- `Y_START`, 60: launch y.
- `X_MAX`, 159: rightmost column.
- `Y_MAX`, 119: bottom row.
- `BULLET_COLOUR`, 3'b111: draw colour; the erase colour is 3'b000.

Ports:
- `clock` in 1: system clock (CLOCK_50 domain).
- `resetn` in 1: one clock; reset is asynchronous and active-low.
- `fire` in 1: launch request, sampled each cycle.
- `direction` in 2: 00 up, 01 down, 10 right, 11 left.
- `tick` in 1: one-cycle step enable from `clock_divider`.
- `x` out 8: pixel column to the VGA adapter.
- `y` out 7: pixel row to the VGA adapter.
- `colour` out 3: pixel colour.
- `plot` out 1: VGA write enable.
- `busy` out 1: a bullet is in flight.
- `done` out 1: one-cycle pulse when the bullet retires.

## Operation
- **States:** IDLE, DRAW, WAIT, ERASE, MOVE. All outputs are Moore, decoded from the state, position and direction registers.
- **IDLE:** `busy`=0, `plot`=0.
  - `fire`=1 latches `direction` into `dir_q` and loads pos=(`X_START`,`Y_START`). Next state is DRAW.
- **DRAW:** `plot`=1, `colour`=`BULLET_COLOUR`, `x`/`y`=pos, for exactly one cycle. Next state is WAIT.
- **WAIT:** `plot`=0.
  - `tick`=1 goes to ERASE; otherwise the block holds in WAIT.
- **ERASE:** `plot`=1, `colour`=000, at the current pos, for one cycle. Next state is MOVE.
- **MOVE:** `plot`=0.
  - Boundary condition, evaluated on `dir_q`: up with y==0, down with y==`Y_MAX`, left with x==0, right with x==`X_MAX`.
  - At the boundary: `done`=1 for this cycle, then IDLE.
  - Otherwise: pos steps ±1 on the `dir_q` axis, then DRAW.
- **Arithmetic:** unsigned, 8-bit x and 7-bit y. The boundary check precedes every step, so pos never wraps.
- **`busy`:** 1 in every state except IDLE.
- **Ignored inputs:**
  - `fire` while `busy` is ignored; there is no queueing.
  - `direction` is sampled only at launch; changes in flight have no effect.
  - `tick` is ignored in every state except WAIT; missed ticks are not accumulated.
- **Simultaneous `fire` and `done`:** `fire` is ignored in MOVE. It is honoured in the following IDLE cycle if still high.
- **Reset mid-flight:** the block goes immediately to IDLE and does not erase the last bullet pixel. Screen clearing belongs to the top level.

## Timing
- **Reset values:**
  - state IDLE
  - pos=(`X_START`,`Y_START`), so `x`=80 and `y`=60
  - `colour`=000
  - `plot`=0, `busy`=0, `done`=0
  - `dir_q`=00
- **Launch latency:** `fire` sampled at edge N gives `plot`=1 (draw) during cycle N+1. `busy` rises at N+1.
- **Tick latency:** `tick` sampled in WAIT at edge M gives:
  - erase during M+1
  - MOVE during M+2
  - draw of the new pixel during M+3
- **`plot` pulses:** each is exactly one cycle wide, with x/y/colour stable throughout that cycle.
- **Retirement:** `done` is high during the MOVE cycle that detects the boundary. `busy` falls on the next edge.
- **Throughput:** at most one pixel step per tick. Requires a tick period ≥4 cycles; a tick arriving outside WAIT is dropped.

## Structure
- Shared package `asteroids_pkg` contains:
  - direction encodings `DIR_UP`/`DIR_DOWN`/`DIR_RIGHT`/`DIR_LEFT`
  - screen constants: 160×120, and `SHIP_X`=80, `SHIP_Y`=60
  - colour constants `COL_BLACK`, `COL_WHITE`
  - bullet state encoding
- No sub-module is required. `tick` comes from the existing `clock_divider` instance at the top level.

## Test plan
- **Reset:**
  - Stimulus: `resetn`=0 with random inputs.
  - Required response: `x`=80, `y`=60, `colour`=000, `plot`/`busy`/`done`=0. Outputs change asynchronously on assertion.
- **Launch up:**
  - Stimulus: `fire`=1, `direction`=00, then one `tick`.
  - Required response:
    - draw (80,60,111)
    - erase (80,60,000)
    - draw (80,59,111) three cycles after the tick
- **Up to edge:**
  - Stimulus: 60 ticks.
  - Required response:
    - The last draw is at (80,0).
    - Tick 61 erases (80,0).
    - `done` pulses for one cycle, `busy` drops, and there is no further plot.
- **Right to edge:**
  - Stimulus: `direction`=10 and 79 ticks.
  - Required response: the last draw is at (159,60); the next tick erases it and pulses `done`.
- **Ignored inputs:**
  - Stimulus:
    - `fire` and a `direction` change mid-flight
    - `tick` during DRAW
  - Required response:
    - The fire and direction change cause no relaunch and no path change.
    - The tick during DRAW does not advance pos.
- **Reset mid-flight:**
  - Stimulus: `resetn` low while in WAIT at (80,40), then `fire` with `direction`=01.
  - Required response: the block is IDLE immediately; the new bullet draws at (80,60), then (80,61).
